// File: rtl/oddr_gear_pkg.sv
// Shared definitions for the ODDR transmit gearbox: FSM encoding, training
// pattern levels and a small width helper for the pair counter.
package oddr_gear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIN = 2'd2
  } state_t;

  localparam logic TRAIN_DA = 1'b1;
  localparam logic TRAIN_DB = 1'b0;

  // Bits needed to count WIDTH/2 pairs (never less than one bit).
  function automatic int cnt_width(int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/oddr_gear_fifo.sv
// Two-entry word FIFO feeding the gearbox; 1-bit wrapping pointers plus a
// separate occupancy count so full/empty come straight from a register.
module oddr_gear_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; the count and pointers decide what is
  // valid, so only they need clearing and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/oddr_tx_gearbox.sv
// Serializes WIDTH-bit words into two registered lanes (even bits on DA, odd bits
// on DB, LSB pair first) for a DDR output register, with an optional training pattern.
module oddr_tx_gearbox
  import oddr_gear_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic             TRAIN,
  output logic             DA,
  output logic             DB,
  output logic             BUSY
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             da_nxt, db_nxt;
  logic             pop;
  logic             boundary;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;

  oddr_gear_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (SCLK),
    .rst_n (RSTN),
    .push  (DIN_VALID && DIN_READY),
    .pop   (pop),
    .din   (DIN),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready depends only on the registered FIFO count, never on DIN_VALID.
  assign DIN_READY = !fifo_full;
  assign BUSY      = (state == ST_SHIFT) || (state == ST_TRAIN);

  // IDLE and TRAIN re-decide every edge; SHIFT only after its last pair.
  assign boundary  = (state != ST_SHIFT) || (cnt == LAST);

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    da_nxt    = DA;
    db_nxt    = DB;
    pop       = 1'b0;
    if (boundary) begin
      if (TRAIN) begin
        state_nxt = ST_TRAIN;
        da_nxt    = TRAIN_DA;
        db_nxt    = TRAIN_DB;
      end else if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ST_SHIFT;
        cnt_nxt   = '0;
        shreg_nxt = head;
        da_nxt    = head[0];
        db_nxt    = head[1];
      end else begin
        state_nxt = ST_IDLE;
        da_nxt    = IDLE_VAL;
        db_nxt    = IDLE_VAL;
      end
    end else begin
      // Shift right by one pair so the next pair always sits at bits [3:2].
      cnt_nxt   = cnt + 1'b1;
      shreg_nxt = {2'b00, shreg[WIDTH-1:2]};
      da_nxt    = shreg[2];
      db_nxt    = shreg[3];
    end
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      DA    <= IDLE_VAL;
      DB    <= IDLE_VAL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      DA    <= da_nxt;
      DB    <= db_nxt;
    end
  end

  always_ff @(posedge SCLK) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_oddr_tx_gearbox.sv
// Self-checking bench for oddr_tx_gearbox: table-driven words through a timed
// scoreboard, plus hand-written training, reset and idle-level sequences.
module tb_oddr_tx_gearbox;

  typedef struct {
    logic [7:0] word;
    logic [7:0] pairs;  // {DA0,DB0, DA1,DB1, DA2,DB2, DA3,DB3}
    int         gap;
  } vec_t;

  typedef struct {
    int   due;
    logic da;
    logic db;
  } pair_t;

  typedef struct {
    int accept;
    int start;
  } word_t;

  logic       SCLK;
  logic       RSTN;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic       TRAIN;
  logic       DA, DB, BUSY;
  logic       da2, db2, busy2, ready2;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_end = -100;
  bit    sb_en = 1'b0;
  pair_t exp_q[$];
  word_t words_q[$];

  oddr_tx_gearbox #(.WIDTH(8), .IDLE_VAL(1'b0)) dut (
    .SCLK      (SCLK),
    .RSTN      (RSTN),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .TRAIN     (TRAIN),
    .DA        (DA),
    .DB        (DB),
    .BUSY      (BUSY)
  );

  // Second instance with the high idle level and no traffic at all.
  oddr_tx_gearbox #(.WIDTH(8), .IDLE_VAL(1'b1)) dut_hi (
    .SCLK      (SCLK),
    .RSTN      (RSTN),
    .DIN       (8'h00),
    .DIN_VALID (1'b0),
    .DIN_READY (ready2),
    .TRAIN     (1'b0),
    .DA        (da2),
    .DB        (db2),
    .BUSY      (busy2)
  );

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  always @(posedge SCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference serialization: pair k is (word[2k], word[2k+1]).
  function automatic logic [7:0] pairs_of(input logic [7:0] w);
    logic [7:0] p;
    for (int k = 0; k < 4; k++) begin
      p[7-2*k] = w[2*k];
      p[6-2*k] = w[2*k+1];
    end
    return p;
  endfunction

  // Words accepted but not yet started, i.e. the FIFO occupancy after edge cyc.
  function automatic int pending_count();
    int n = 0;
    foreach (words_q[j])
      if (words_q[j].accept <= cyc && words_q[j].start > cyc) n++;
    return n;
  endfunction

  // Word is accepted on the coming edge; it starts right after the previous word.
  task automatic accept_word(input logic [7:0] pairs);
    int e;
    int start;
    e     = cyc + 1;
    start = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{start + k, pairs[7-2*k], pairs[6-2*k]});
    last_end = start + 3;
    words_q.push_back('{e, start});
  endtask

  // Advance to the next falling edge and compare everything the scoreboard predicts.
  task automatic step();
    pair_t e;
    @(negedge SCLK);
    check("idle_hi_lane", 8'({busy2, ready2, da2, db2}), 8'b0111);
    if (sb_en) begin
      while (words_q.size() != 0 && words_q[0].start <= cyc) void'(words_q.pop_front());
      check("din_ready", 8'(DIN_READY), 8'(pending_count() < 2));
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("pair", 8'({BUSY, DA, DB}), 8'({1'b1, e.da, e.db}));
      end else begin
        check("idle", 8'({BUSY, DA, DB}), 8'b000);
      end
    end
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] bp_words[6];
    logic [2:0] tr_exp[1:12];
    int         i;
    int         guard;
    int         e0;
    bit         saw_low;

    vecs[0] = '{8'hB4, 8'b00_10_11_01, 6};
    vecs[1] = '{8'h01, 8'b10_00_00_00, 6};
    vecs[2] = '{8'h80, 8'b00_00_00_01, 6};
    vecs[3] = '{8'hC6, 8'b01_10_00_11, 6};
    vecs[4] = '{8'hFF, 8'b11_11_11_11, 0};
    vecs[5] = '{8'h00, 8'b00_00_00_00, 8};
    vecs[6] = '{8'h3C, 8'b00_11_11_00, 6};

    bp_words = '{8'h1E, 8'hA7, 8'h3C, 8'hD2, 8'h69, 8'hF0};

    // {BUSY,DA,DB} after edges e0+1..e0+12 for the training sequence.
    tr_exp = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b110,
               3'b110, 3'b101, 3'b110, 3'b110, 3'b101, 3'b000};

    RSTN      = 1'b1;
    DIN       = 8'h00;
    DIN_VALID = 1'b0;
    TRAIN     = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    check("reset_state", 8'({BUSY, DA, DB, DIN_READY}), 8'b0001);
    check("reset_state_hi", 8'({busy2, da2, db2, ready2}), 8'b0111);
    repeat (3) step();
    RSTN = 1'b1;
    step();

    // Table-driven words through the scoreboard.
    sb_en = 1'b1;
    step();
    for (int v = 0; v < 7; v++) begin
      DIN       = vecs[v].word;
      DIN_VALID = 1'b1;
      accept_word(vecs[v].pairs);
      step();
      DIN_VALID = 1'b0;
      for (int g = 0; g < vecs[v].gap; g++) step();
    end

    // Backpressure: valid held high for six words while the FSM is busy.
    i       = 0;
    guard   = 0;
    saw_low = 1'b0;
    while (i < 6 && guard < 100) begin
      DIN       = bp_words[i];
      DIN_VALID = 1'b1;
      if (pending_count() < 2) begin
        accept_word(pairs_of(bp_words[i]));
        i++;
      end else if (!DIN_READY) begin
        saw_low = 1'b1;
      end
      step();
      guard++;
    end
    DIN_VALID = 1'b0;
    check("bp_ready_fell", 8'(saw_low), 8'd1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      step();
      guard++;
    end
    check("bp_drain", 8'(exp_q.size()), 8'd0);
    repeat (2) step();

    // Training raised mid-word, a second word queued behind it.
    sb_en     = 1'b0;
    e0        = cyc + 1;
    DIN       = 8'hAA;
    DIN_VALID = 1'b1;
    step();
    DIN = 8'h96;
    step();
    DIN_VALID = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      check("train_seq", 8'({BUSY, DA, DB}), 8'(tr_exp[t]));
      check("train_cycle", 8'(cyc - e0), 8'(t));
      if (t == 2) TRAIN = 1'b1;
      if (t == 7) TRAIN = 1'b0;
      step();
    end
    repeat (2) step();

    // Reset mid-word with a full FIFO behind the word in flight.
    DIN       = 8'hE1;
    DIN_VALID = 1'b1;
    step();
    DIN = 8'h7E;
    step();
    DIN = 8'h55;
    step();
    DIN_VALID = 1'b0;
    step();
    check("pre_reset", 8'({BUSY, DA, DB, DIN_READY}), 8'b1010);
    RSTN = 1'b0;
    #1;
    check("async_reset", 8'({BUSY, DA, DB, DIN_READY}), 8'b0001);
    repeat (2) step();
    RSTN = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      check("post_reset_idle", 8'({BUSY, DA, DB, DIN_READY}), 8'b0001);
    end

    // Normal traffic resumes after reset.
    exp_q.delete();
    words_q.delete();
    last_end  = -100;
    sb_en     = 1'b1;
    DIN       = vecs[0].word;
    DIN_VALID = 1'b1;
    accept_word(vecs[0].pairs);
    step();
    DIN_VALID = 1'b0;
    repeat (7) step();
    check("final_drain", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
